// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: N-to-1 valid/ready multiplexer with round-robin arbitration
// and a registered output stage (one cycle from input beat to out_valid).
// Optional feature macro: RR_MUX_BURST_EN lets the current grantee keep the
// grant for up to BURST_MAX consecutive beats before the rotation moves on.
//
// Handshake: a beat moves from channel k into the output register on a rising
// edge where in_valid[k] && in_ready[k]; the output beat moves to the consumer
// on a rising edge where out_valid && out_ready. A producer must hold its
// in_data/in_valid until it sees in_ready; out_data/out_channel stay stable
// while out_valid && !out_ready.
module rr_mux_arbiter #(
   parameter int WIDTH     = 8,
   parameter int CHANNELS  = 4,
   parameter int BURST_MAX = 4
) (
   input  logic                          clock,
   input  logic                          reset_n,
   input  logic [CHANNELS*WIDTH-1:0]     in_data,
   input  logic [CHANNELS-1:0]           in_valid,
   output logic [CHANNELS-1:0]           in_ready,
   output logic [WIDTH-1:0]              out_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [$clog2(CHANNELS)-1:0]   out_channel
);

   localparam int SEL_W = $clog2(CHANNELS);

   logic             load;
   logic [SEL_W-1:0] last_grant;
   logic [SEL_W-1:0] grant_idx;
   logic             grant_any;
   logic [WIDTH-1:0] grant_data;
   logic             keep;

   // The output register can take a new beat when empty or being drained.
   assign load = !out_valid || out_ready;

`ifdef RR_MUX_BURST_EN
   localparam int CNT_W = $clog2(BURST_MAX + 1);

   logic [CNT_W-1:0] burst_cnt;

   // The grantee keeps the grant while its burst is open and it still requests.
   assign keep = (burst_cnt != '0) && (int'(burst_cnt) < BURST_MAX) && in_valid[last_grant];

   // Burst length: restarts at 1 on a fresh grant, clears when a load finds no requester.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         burst_cnt <= '0;
      end else if (load) begin
         if (!grant_any) begin
            burst_cnt <= '0;
         end else if (keep) begin
            burst_cnt <= burst_cnt + 1'b1;
         end else begin
            burst_cnt <= CNT_W'(1);
         end
      end
   end
`else
   logic unused_burst;

   assign keep         = 1'b0;
   assign unused_burst = (BURST_MAX > 0);
`endif

   // Pick the first requester at or after last_grant+1, wrapping around.
   always_comb begin
      int k;
      k         = 0;
      grant_any = 1'b0;
      grant_idx = last_grant;
      if (keep) begin
         grant_any = 1'b1;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            k = (int'(last_grant) + 1 + i) % CHANNELS;
            if (!grant_any && in_valid[k]) begin
               grant_any = 1'b1;
               grant_idx = SEL_W'(k);
            end
         end
      end
   end

   // Route the selected channel's data toward the output register.
   always_comb begin
      grant_data = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         if (grant_idx == SEL_W'(k)) begin
            grant_data = in_data[k*WIDTH +: WIDTH];
         end
      end
   end

   // Accept strobe: one-hot on the winner, only when the output can load.
   always_comb begin
      in_ready = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         if (load && grant_any && (grant_idx == SEL_W'(k))) begin
            in_ready[k] = 1'b1;
         end
      end
   end

   // Output register and rotation pointer; both hold while the consumer stalls.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         out_valid   <= 1'b0;
         out_data    <= '0;
         out_channel <= '0;
         last_grant  <= SEL_W'(CHANNELS - 1);
      end else if (load) begin
         if (grant_any) begin
            out_valid   <= 1'b1;
            out_data    <= grant_data;
            out_channel <= grant_idx;
            last_grant  <= grant_idx;
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule
